packer_nx_word: RTL and testbench
=================================

// Module: packer_nx_word
// PURPOSE
//   Parametrised successor of the 8->32 packer. Packs IN_LEN-bit samples from the
//   LVDS receiver into RATIO-lane words for the dual-port FIFO. Adds:
//   - a one-word output register with valid/ready handshake,
//   - overflow drop accounting,
//   - synchronous clear,
//   - optional timeout flush of a partial word with lane-keep mask.
//   Sits between the LVDS block (clk_o domain) and fifo_dualport write port.
// PARAMETERS
//   IN_LEN        8   width of one input sample (lane)
//   RATIO         4   lanes per output word; power of two, >=2
//   DATA_LEN      IN_LEN*RATIO  output word width (derived, do not override)
//   FLUSH_TIMEOUT 16  idle cycles before a partial word is flushed (flush build only)
//   DROP_CNT_LEN  16  width of the dropped-word counter
// PORTS
//   clk        in   1             sample clock (LVDS clk_o)
//   rst        in   1             async reset, active-high
//   clear_i    in   1             sync clear of packing state and statistics
//   valid_in   in   1             sample strobe
//   data_in    in   IN_LEN        sample
//   valid_out  out  1             word available
//   ready_in   in   1             consumer accepts word (FIFO ~full)
//   data_out   out  DATA_LEN      packed word
//   keep_out   out  RATIO         valid lanes of data_out
//   drop_cnt_o out  DROP_CNT_LEN  words dropped for lack of space; saturating
//   overflow_o out  1             sticky: at least one word dropped
// BEHAVIOUR
// - Reset: valid_out, data_out, keep_out, drop_cnt_o, overflow_o = 0; lane count and
//   accumulator = 0.
// - Input is never stalled. Each cycle with valid_in=1 writes data_in to lane lane_cnt.
//   Lane 0 maps to [IN_LEN-1:0] (little-endian). lane_cnt then wraps modulo RATIO.
// - Completion: on the cycle the RATIO-th lane is accepted, the word is transferred to
//   the output register if the register is empty or is being consumed that cycle
//   (valid_out & ready_in). valid_out rises on the next edge.
//   Latency: last lane -> valid_out = 1 cycle. keep_out = all ones.
// - Transfer: valid_out holds, and data_out/keep_out stay stable, until the cycle with
//   valid_out & ready_in. valid_out then drops, unless a new word loads that same cycle.
//   Back-to-back words at full rate must not drop.
// - Drop: a completed word with the output register full and not consumed is
//   discarded. drop_cnt_o increments and saturates at all ones; overflow_o sets.
//   The packer still restarts at lane 0.
// - clear_i (sync, priority over valid_in):
//   - zeroes lane_cnt, accumulator, idle counter, drop_cnt_o, overflow_o.
//   - A sample presented with clear_i is discarded.
//   - The output register and valid_out are untouched.
// - Gaps in valid_in (pauses) do not disturb the partial word.
// CONFIGURATION
//   PACKER_FLUSH_EN defined:
//   - An idle counter runs while valid_in=0 and lane_cnt!=0, and resets on valid_in=1.
//   - When it reaches FLUSH_TIMEOUT, the partial word is completed with the same
//     load/drop rule. Unused lanes = 0; keep_out bit k = 1 for k < lane_cnt.
//   - lane_cnt then returns to 0.
//   PACKER_FLUSH_EN undefined:
//   - No idle counter. Partial words wait indefinitely; keep_out is constant all ones.
// STRUCTURE
// - packer_pkg:
//   - LANE_W = $clog2(RATIO)
//   - function keep_mask(lane_cnt) -> RATIO-bit mask
//   - saturating increment function
// - Sub-module packer_out_stage: one-word output register. Implements the valid/ready
//   hold, load-while-consume and drop decision; returns accepted/dropped flags.
// - Top holds the lane counter, accumulator, idle counter and statistics.
// TESTING
// 1. ready_in=1; bytes 01..08 back-to-back -> 0x04030201 then 0x08070605.
//    valid_out 1 cycle after bytes 04 and 08; keep_out=4'hF; drop_cnt_o=0.
// 2. Bytes 11,22, 3-cycle strobe gap, 33,44 -> single word 0x44332211.
// 3. ready_in=0; bytes 01..08 -> 0x04030201 held stable, second word dropped,
//    drop_cnt_o=1, overflow_o=1. Then ready_in=1 -> exactly one word delivered.
// 4. PACKER_FLUSH_EN, FLUSH_TIMEOUT=16; bytes AA,BB then idle:
//    - data_out=0x0000BBAA, keep_out=4'h3, valid_out on 16th idle cycle + 1.
//    - Without the macro: no word emitted.
// 5. Bytes 01,02 then rst pulse mid-word, then 01..04 -> only 0x04030201.
//    clear_i with 2 lanes pending -> drop_cnt_o=0 and next 4 bytes form a fresh word.
// 6. IN_LEN=4, RATIO=8, 256 random nibbles at full rate, ready_in=1 ->
//    32 words matching reference model, zero drops.

Source files
------------

// File: rtl/packer_pkg.sv
// Shared helpers for the N-lane word packer: lane-counter sizing, keep masks
// and saturating counters.
package packer_pkg;

   localparam int unsigned MAX_W = 32;

   // Lane counter width for a power-of-two lane count.
   function automatic int unsigned lane_width(input int unsigned ratio);
      return $clog2(ratio);
   endfunction

   // Mask with one bit set for each of the lowest 'lanes' lanes.
   function automatic logic [MAX_W-1:0] keep_mask(input int unsigned lanes);
      logic [MAX_W-1:0] mask;
      if (lanes >= MAX_W) mask = '1;
      else                mask = (MAX_W'(1) << lanes) - MAX_W'(1);
      return mask;
   endfunction

   // Increment v, holding at the all-ones value of a w-bit counter.
   function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v,
                                                input int unsigned       w);
      logic [MAX_W-1:0] max_v;
      if (w >= MAX_W) max_v = '1;
      else            max_v = (MAX_W'(1) << w) - MAX_W'(1);
      return (v >= max_v) ? max_v : v + MAX_W'(1);
   endfunction

endpackage

// File: rtl/packer_out_stage.sv
// One-word output register with valid/ready hold, load-while-consume and
// drop decision for a completed word that finds no space.
module packer_out_stage #(
   parameter int unsigned DATA_LEN = 32,
   parameter int unsigned RATIO    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_req_i,
   input  logic [DATA_LEN-1:0] word_i,
   input  logic [RATIO-1:0]    keep_i,
   input  logic                ready_i,
   output logic                valid_o,
   output logic [DATA_LEN-1:0] data_o,
   output logic [RATIO-1:0]    keep_o,
   output logic                drop_c
);

   logic                valid_q, valid_d;
   logic [DATA_LEN-1:0] data_q, data_d;
   logic [RATIO-1:0]    keep_q, keep_d;
   logic                consume_c;
   logic                accept_c;

   // Space exists if the register is empty or is handed off this cycle.
   assign consume_c = valid_q & ready_i;
   assign accept_c  = load_req_i & (~valid_q | consume_c);
   assign drop_c    = load_req_i & ~accept_c;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      keep_d  = keep_q;
      if (accept_c) begin
         valid_d = 1'b1;
         data_d  = word_i;
         keep_d  = keep_i;
      end else if (consume_c) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign keep_o  = keep_q;

endmodule

// File: rtl/packer_nx_word.sv
// Packs IN_LEN-bit samples into RATIO-lane words with drop accounting.
// Define PACKER_FLUSH_EN to flush partial words after FLUSH_TIMEOUT idle cycles.
module packer_nx_word
   import packer_pkg::*;
#(
   parameter int unsigned IN_LEN        = 8,
   parameter int unsigned RATIO         = 4,
   parameter int unsigned DATA_LEN      = IN_LEN * RATIO,
   parameter int unsigned FLUSH_TIMEOUT = 16,
   parameter int unsigned DROP_CNT_LEN  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear_i,
   input  logic                    valid_in,
   input  logic [IN_LEN-1:0]       data_in,
   output logic                    valid_out,
   input  logic                    ready_in,
   output logic [DATA_LEN-1:0]     data_out,
   output logic [RATIO-1:0]        keep_out,
   output logic [DROP_CNT_LEN-1:0] drop_cnt_o,
   output logic                    overflow_o
);

   localparam int unsigned LANE_W = lane_width(RATIO);
   localparam int unsigned IDLE_W = $clog2(FLUSH_TIMEOUT + 1);

   if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || RATIO > MAX_W ||
       DATA_LEN != IN_LEN * RATIO || DROP_CNT_LEN > MAX_W ||
       DROP_CNT_LEN == 0 || FLUSH_TIMEOUT == 0) begin : g_bad_params
      $error("packer_nx_word: unsupported parameter combination");
   end

   logic [LANE_W-1:0]       lane_q, lane_d;
   logic [DATA_LEN-1:0]     acc_q, acc_d;
   logic [DROP_CNT_LEN-1:0] drop_q, drop_d;
   logic                    ovf_q, ovf_d;
`ifdef PACKER_FLUSH_EN
   logic [IDLE_W-1:0]       idle_q, idle_d;
`endif

   logic                    load_req_c;
   logic [DATA_LEN-1:0]     word_c;
   logic [RATIO-1:0]        keep_c;
   logic                    drop_c;

   always_comb begin
      lane_d     = lane_q;
      acc_d      = acc_q;
      drop_d     = drop_q;
      ovf_d      = ovf_q;
      load_req_c = 1'b0;
      word_c     = acc_q;
      keep_c     = '1;
`ifdef PACKER_FLUSH_EN
      idle_d     = idle_q;
`endif
      if (clear_i) begin
         lane_d = '0;
         acc_d  = '0;
         drop_d = '0;
         ovf_d  = 1'b0;
`ifdef PACKER_FLUSH_EN
         idle_d = '0;
`endif
      end else begin
         if (valid_in) begin
            word_c[32'(lane_q) * IN_LEN +: IN_LEN] = data_in;
`ifdef PACKER_FLUSH_EN
            idle_d = '0;
`endif
            if (lane_q == LANE_W'(RATIO - 1)) begin
               load_req_c = 1'b1;
               lane_d     = '0;
               acc_d      = '0;
            end else begin
               lane_d = lane_q + LANE_W'(1);
               acc_d  = word_c;
            end
`ifdef PACKER_FLUSH_EN
         end else if (lane_q != '0) begin
            // Idle partial word: unwritten lanes are already zero in acc_q.
            if (idle_q == IDLE_W'(FLUSH_TIMEOUT - 1)) begin
               load_req_c = 1'b1;
               keep_c     = RATIO'(keep_mask(32'(lane_q)));
               lane_d     = '0;
               acc_d      = '0;
               idle_d     = '0;
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
`endif
         end
         if (drop_c) begin
            drop_d = DROP_CNT_LEN'(sat_inc(MAX_W'(drop_q), DROP_CNT_LEN));
            ovf_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q <= '0;
         acc_q  <= '0;
         drop_q <= '0;
         ovf_q  <= 1'b0;
`ifdef PACKER_FLUSH_EN
         idle_q <= '0;
`endif
      end else begin
         lane_q <= lane_d;
         acc_q  <= acc_d;
         drop_q <= drop_d;
         ovf_q  <= ovf_d;
`ifdef PACKER_FLUSH_EN
         idle_q <= idle_d;
`endif
      end
   end

   packer_out_stage #(
      .DATA_LEN (DATA_LEN),
      .RATIO    (RATIO)
   ) u_out_stage (
      .clk        (clk),
      .rst        (rst),
      .load_req_i (load_req_c),
      .word_i     (word_c),
      .keep_i     (keep_c),
      .ready_i    (ready_in),
      .valid_o    (valid_out),
      .data_o     (data_out),
      .keep_o     (keep_out),
      .drop_c     (drop_c)
   );

   assign drop_cnt_o = drop_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_packer_nx_word.sv
// Directed bench for packer_nx_word: default 8x4 instance plus a 4x8 instance.
// Flush checks follow the PACKER_FLUSH_EN define.
module tb_packer_nx_word;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear_i, valid_in, ready_in;
   logic [7:0]  data_in;
   logic        valid_out, overflow_o;
   logic [31:0] data_out;
   logic [3:0]  keep_out;
   logic [15:0] drop_cnt_o;

   logic        clear8, valid8_in, ready8, valid8_out, ovf8;
   logic [3:0]  data8_in;
   logic [31:0] data8_out;
   logic [7:0]  keep8;
   logic [15:0] drop8;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   packer_nx_word u_dut (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (clear_i),
      .valid_in   (valid_in),
      .data_in    (data_in),
      .valid_out  (valid_out),
      .ready_in   (ready_in),
      .data_out   (data_out),
      .keep_out   (keep_out),
      .drop_cnt_o (drop_cnt_o),
      .overflow_o (overflow_o)
   );

   packer_nx_word #(.IN_LEN(4), .RATIO(8)) u_dut8 (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (clear8),
      .valid_in   (valid8_in),
      .data_in    (data8_in),
      .valid_out  (valid8_out),
      .ready_in   (ready8),
      .data_out   (data8_out),
      .keep_out   (keep8),
      .drop_cnt_o (drop8),
      .overflow_o (ovf8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      valid_in = 1'b1;
      data_in  = b;
      step();
      valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   logic [31:0] exp_q[$];
   logic [31:0] exp_w;
   logic [3:0]  nib;
   int          words;

   initial begin
      rst = 1'b1; clear_i = 1'b0; valid_in = 1'b0; data_in = '0; ready_in = 1'b1;
      clear8 = 1'b0; valid8_in = 1'b0; data8_in = '0; ready8 = 1'b1;
      #12;
      check("rst_valid", valid_out, 0);
      check("rst_data", data_out, 0);
      check("rst_keep", keep_out, 0);
      check("rst_drop", drop_cnt_o, 0);
      check("rst_ovf", overflow_o, 0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Test 1: back-to-back bytes, consumer always ready
      for (int i = 1; i <= 3; i++) send(8'(i));
      check("t1_not_yet", valid_out, 0);
      send(8'h04);
      check("t1_w0_valid", valid_out, 1);
      check("t1_w0_data", data_out, 32'h04030201);
      check("t1_w0_keep", keep_out, 4'hF);
      send(8'h05);
      check("t1_consumed", valid_out, 0);
      send(8'h06); send(8'h07); send(8'h08);
      check("t1_w1_valid", valid_out, 1);
      check("t1_w1_data", data_out, 32'h08070605);
      idle(1);
      check("t1_idle", valid_out, 0);
      check("t1_drop", drop_cnt_o, 0);

      // Test 2: gap in the strobe keeps the partial word
      send(8'h11); send(8'h22);
      idle(3);
      send(8'h33);
      check("t2_gap_no_word", valid_out, 0);
      send(8'h44);
      check("t2_valid", valid_out, 1);
      check("t2_data", data_out, 32'h44332211);
      idle(1);

      // Test 3: consumer stalled, second word dropped
      ready_in = 1'b0;
      for (int i = 1; i <= 4; i++) send(8'(i));
      check("t3_w0_valid", valid_out, 1);
      for (int i = 5; i <= 8; i++) send(8'(i));
      check("t3_hold_valid", valid_out, 1);
      check("t3_hold_data", data_out, 32'h04030201);
      check("t3_drop", drop_cnt_o, 1);
      check("t3_ovf", overflow_o, 1);
      ready_in = 1'b1;
      idle(1);
      check("t3_one_word", valid_out, 0);
      idle(2);
      check("t3_no_second", valid_out, 0);

      // Test 5b: clear with two lanes pending, sample under clear discarded
      send(8'hA1); send(8'hA2);
      clear_i = 1'b1; valid_in = 1'b1; data_in = 8'hEE;
      step();
      clear_i = 1'b0; valid_in = 1'b0;
      check("t5_clr_drop", drop_cnt_o, 0);
      check("t5_clr_ovf", overflow_o, 0);
      check("t5_clr_valid", valid_out, 0);
      for (int i = 5; i <= 8; i++) send(8'(i));
      check("t5_clr_word_v", valid_out, 1);
      check("t5_clr_word", data_out, 32'h08070605);
      idle(1);

      // Test 5a: reset mid-word
      send(8'h01); send(8'h02);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      check("t5_rst_valid", valid_out, 0);
      check("t5_rst_data", data_out, 0);
      for (int i = 1; i <= 3; i++) send(8'(i));
      check("t5_rst_partial", valid_out, 0);
      send(8'h04);
      check("t5_rst_word_v", valid_out, 1);
      check("t5_rst_word", data_out, 32'h04030201);
      idle(1);

      // Test 4: partial word left idle
      send(8'hAA); send(8'hBB);
`ifdef PACKER_FLUSH_EN
      idle(15);
      check("t4_before_to", valid_out, 0);
      idle(1);
      check("t4_flush_v", valid_out, 1);
      check("t4_flush_data", data_out, 32'h0000BBAA);
      check("t4_flush_keep", keep_out, 4'h3);
      idle(1);
      check("t4_after", valid_out, 0);
`else
      idle(40);
      check("t4_no_flush", valid_out, 0);
      check("t4_keep_const", keep_out, 4'hF);
`endif

      // Test 6: 4-bit samples, 8 lanes, random nibbles at full rate
      words = 0;
      exp_w = '0;
      for (int i = 0; i < 256; i++) begin
         nib = 4'($urandom_range(0, 15));
         exp_w[(i % 8) * 4 +: 4] = nib;
         if (i % 8 == 7) begin
            exp_q.push_back(exp_w);
            exp_w = '0;
         end
         valid8_in = 1'b1;
         data8_in  = nib;
         step();
         if (valid8_out) begin
            words++;
            if (exp_q.size() == 0) check("t6_unexpected", 1, 0);
            else check("t6_word", data8_out, exp_q.pop_front());
         end
      end
      valid8_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (valid8_out) begin
            words++;
            if (exp_q.size() == 0) check("t6_unexpected", 1, 0);
            else check("t6_word", data8_out, exp_q.pop_front());
         end
      end
      check("t6_count", words, 32);
      check("t6_left", exp_q.size(), 0);
      check("t6_drop", drop8, 0);
      check("t6_ovf", ovf8, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
